// File: rtl/spectrum_pkg.sv
// rtl/spectrum_pkg.sv - shared types and sizes for the spectrum ballistics block
package spectrum_pkg;
  localparam int BAND_NUM = 8;
  localparam int BAND_W   = 8;

  typedef enum logic [1:0] {IDLE, UPDATE, DONE} state_e;
  typedef logic [2:0]        band_idx_t;
  typedef logic [BAND_W-1:0] mag_t;
endpackage

// File: rtl/band_ballistics.sv
// rtl/band_ballistics.sv - combinational per-band level/peak ballistics step
// Peak/hold datapath present only when PEAK_HOLD_EN is defined.
module band_ballistics
  import spectrum_pkg::*;
#(
  parameter int DECAY_SHIFT = 3,
  parameter int HOLD_FRAMES = 16,
  parameter int PEAK_FALL   = 2,
  parameter int HOLD_W      = 5
) (
  input  mag_t              in_i,
  input  mag_t              level_i,
`ifdef PEAK_HOLD_EN
  input  mag_t              peak_i,
  input  logic [HOLD_W-1:0] hold_i,
  output mag_t              peak_o,
  output logic [HOLD_W-1:0] hold_o,
`endif
  output mag_t              level_o
);

  mag_t diff;
  mag_t step;
  mag_t dec;

  always_comb begin
    diff = level_i - in_i;
    step = diff >> DECAY_SHIFT;
    if (step == '0) step = mag_t'(1);
    dec = level_i - step;
    if (in_i >= level_i) begin
      level_o = in_i;
    end else begin
      level_o = (dec < in_i) ? in_i : dec;
    end
  end

`ifdef PEAK_HOLD_EN
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_FRAMES);
  localparam logic [BAND_W:0]   FALL_W    = (BAND_W+1)'(PEAK_FALL);

  logic [BAND_W:0] floor_w;

  // Falling peak never drops below the freshly computed level.
  always_comb begin
    floor_w = {1'b0, level_o} + FALL_W;
    peak_o  = peak_i;
    hold_o  = hold_i;
    if (in_i >= peak_i) begin
      peak_o = in_i;
      hold_o = HOLD_INIT;
    end else if (hold_i != '0) begin
      hold_o = hold_i - 1'b1;
    end else if ({1'b0, peak_i} < floor_w) begin
      peak_o = level_o;
    end else begin
      peak_o = peak_i - FALL_W[BAND_W-1:0];
    end
  end
`endif

endmodule

// File: rtl/spectrum_ballistics.sv
// rtl/spectrum_ballistics.sv - 8-band bar/peak ballistics, one band per clock
// Optional peak-hold logic enabled by defining PEAK_HOLD_EN.
module spectrum_ballistics
  import spectrum_pkg::*;
#(
  parameter int DECAY_SHIFT = 3,
  parameter int HOLD_FRAMES = 16,
  parameter int PEAK_FALL   = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       spectrum_valid,
  input  logic [BAND_W-1:0]          spectrum_0,
  input  logic [BAND_W-1:0]          spectrum_1,
  input  logic [BAND_W-1:0]          spectrum_2,
  input  logic [BAND_W-1:0]          spectrum_3,
  input  logic [BAND_W-1:0]          spectrum_4,
  input  logic [BAND_W-1:0]          spectrum_5,
  input  logic [BAND_W-1:0]          spectrum_6,
  input  logic [BAND_W-1:0]          spectrum_7,
  output logic [BAND_NUM*BAND_W-1:0] level_bus,
  output logic [BAND_NUM*BAND_W-1:0] peak_bus,
  output logic                       out_valid,
  output logic                       busy,
  output logic                       drop
);

  state_e    state_q, state_d;
  band_idx_t band_q, band_d;
  logic      snap_load, band_we, drop_d;
  logic      out_valid_q, busy_q, drop_q;
  mag_t      snap_q  [BAND_NUM];
  mag_t      level_q [BAND_NUM];
  mag_t      level_n;

  always_comb begin
    state_d   = state_q;
    band_d    = band_q;
    snap_load = 1'b0;
    band_we   = 1'b0;
    drop_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (spectrum_valid) begin
          snap_load = 1'b1;
          band_d    = '0;
          state_d   = UPDATE;
        end
      end
      UPDATE: begin
        band_we = 1'b1;
        band_d  = band_q + 1'b1;
        drop_d  = spectrum_valid;
        if (band_q == band_idx_t'(BAND_NUM-1)) state_d = DONE;
      end
      DONE: begin
        drop_d  = spectrum_valid;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef PEAK_HOLD_EN
  localparam int HOLD_W = $clog2(HOLD_FRAMES+1);

  mag_t              peak_q [BAND_NUM];
  logic [HOLD_W-1:0] hold_q [BAND_NUM];
  mag_t              peak_n;
  logic [HOLD_W-1:0] hold_n;

  band_ballistics #(
    .DECAY_SHIFT(DECAY_SHIFT),
    .HOLD_FRAMES(HOLD_FRAMES),
    .PEAK_FALL  (PEAK_FALL),
    .HOLD_W     (HOLD_W)
  ) u_band (
    .in_i   (snap_q[band_q]),
    .level_i(level_q[band_q]),
    .peak_i (peak_q[band_q]),
    .hold_i (hold_q[band_q]),
    .peak_o (peak_n),
    .hold_o (hold_n),
    .level_o(level_n)
  );
`else
  localparam int unused_peak_cfg = HOLD_FRAMES + PEAK_FALL;

  band_ballistics #(
    .DECAY_SHIFT(DECAY_SHIFT)
  ) u_band (
    .in_i   (snap_q[band_q]),
    .level_i(level_q[band_q]),
    .level_o(level_n)
  );
`endif

  // Reset and clear share one path: both discard any partial frame silently.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state_q     <= IDLE;
      band_q      <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      drop_q      <= 1'b0;
      for (int k = 0; k < BAND_NUM; k++) begin
        snap_q[k]  <= '0;
        level_q[k] <= '0;
`ifdef PEAK_HOLD_EN
        peak_q[k]  <= '0;
        hold_q[k]  <= '0;
`endif
      end
    end else begin
      state_q     <= state_d;
      band_q      <= band_d;
      out_valid_q <= (state_q == DONE);
      busy_q      <= (state_d != IDLE);
      drop_q      <= drop_d;
      if (snap_load) begin
        snap_q[0] <= spectrum_0;
        snap_q[1] <= spectrum_1;
        snap_q[2] <= spectrum_2;
        snap_q[3] <= spectrum_3;
        snap_q[4] <= spectrum_4;
        snap_q[5] <= spectrum_5;
        snap_q[6] <= spectrum_6;
        snap_q[7] <= spectrum_7;
      end
      if (band_we) begin
        level_q[band_q] <= level_n;
`ifdef PEAK_HOLD_EN
        peak_q[band_q]  <= peak_n;
        hold_q[band_q]  <= hold_n;
`endif
      end
    end
  end

  always_comb begin
    level_bus = '0;
    peak_bus  = '0;
    for (int k = 0; k < BAND_NUM; k++) begin
      level_bus[k*BAND_W +: BAND_W] = level_q[k];
`ifdef PEAK_HOLD_EN
      peak_bus[k*BAND_W +: BAND_W]  = peak_q[k];
`else
      peak_bus[k*BAND_W +: BAND_W]  = level_q[k];
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign drop      = drop_q;

endmodule

// File: tb/tb_spectrum_ballistics.sv
// tb/tb_spectrum_ballistics.sv - directed self-checking bench for spectrum_ballistics
module tb_spectrum_ballistics;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        valid = 1'b0;
  logic [7:0]  sv [8];
  logic [63:0] level_bus, peak_bus;
  logic        out_valid, busy, drop;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  spectrum_ballistics #(.DECAY_SHIFT(3), .HOLD_FRAMES(2), .PEAK_FALL(2)) dut (
    .clk(clk), .rst(rst), .clear(clear), .spectrum_valid(valid),
    .spectrum_0(sv[0]), .spectrum_1(sv[1]), .spectrum_2(sv[2]), .spectrum_3(sv[3]),
    .spectrum_4(sv[4]), .spectrum_5(sv[5]), .spectrum_6(sv[6]), .spectrum_7(sv[7]),
    .level_bus(level_bus), .peak_bus(peak_bus),
    .out_valid(out_valid), .busy(busy), .drop(drop)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rep(input logic [7:0] v);
    return {8{v}};
  endfunction

  function automatic logic [63:0] pk(input logic [63:0] p, input logic [63:0] l);
`ifdef PEAK_HOLD_EN
    return p;
`else
    return l;
`endif
  endfunction

  task automatic set_all(input logic [7:0] v);
    for (int k = 0; k < 8; k++) sv[k] = v;
  endtask

  task automatic do_frame(input string tag, input bit ovr);
    int busy_cnt, ov_cnt, ov_first, drop_cnt;
    @(negedge clk); valid = 1'b1;
    @(negedge clk); valid = 1'b0;
    busy_cnt = int'(busy); ov_cnt = 0; ov_first = -1; drop_cnt = int'(drop);
    for (int n = 1; n <= 11; n++) begin
      @(negedge clk);
      busy_cnt += int'(busy);
      drop_cnt += int'(drop);
      if (out_valid) begin
        ov_cnt++;
        if (ov_first < 0) ov_first = n;
      end
      if (ovr && n == 3) begin set_all(8'd250); valid = 1'b1; end
      if (ovr && n == 4) valid = 1'b0;
    end
    chk({tag, "_ov_first"}, 64'(ov_first), 64'd9);
    chk({tag, "_ov_cnt"},   64'(ov_cnt),   64'd1);
    chk({tag, "_busy_cnt"}, 64'(busy_cnt), 64'd9);
    chk({tag, "_drop_cnt"}, 64'(drop_cnt), ovr ? 64'd1 : 64'd0);
  endtask

  task automatic check_bus(input string tag, input logic [63:0] l, input logic [63:0] p);
    chk({tag, "_level"}, level_bus, l);
    chk({tag, "_peak"},  peak_bus,  pk(p, l));
  endtask

  task automatic expect_quiet(input string tag);
    int ov_cnt = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      ov_cnt += int'(out_valid);
    end
    chk({tag, "_no_out_valid"}, 64'(ov_cnt), 64'd0);
  endtask

  logic [63:0] exp_l, exp_p;

  initial begin
    set_all(8'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_bus("reset", 64'd0, 64'd0);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_busy",      64'(busy),      64'd0);
    chk("reset_drop",      64'(drop),      64'd0);

    set_all(8'd200); do_frame("attack", 1'b0);
    check_bus("attack", rep(8'd200), rep(8'd200));

    set_all(8'd0);
    do_frame("decay1", 1'b0); check_bus("decay1", rep(8'd175), rep(8'd200));
    do_frame("decay2", 1'b0); check_bus("decay2", rep(8'd154), rep(8'd200));
    do_frame("decay3", 1'b0); check_bus("decay3", rep(8'd135), rep(8'd198));
    do_frame("decay4", 1'b0); check_bus("decay4", rep(8'd119), rep(8'd196));

    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    check_bus("clear", 64'd0, 64'd0);

    set_all(8'd5); do_frame("min0", 1'b0); check_bus("min0", rep(8'd5), rep(8'd5));
    set_all(8'd3);
    do_frame("min1", 1'b0); check_bus("min1", rep(8'd4), rep(8'd5));
    do_frame("min2", 1'b0); check_bus("min2", rep(8'd3), rep(8'd5));
    do_frame("min3", 1'b0); check_bus("min3", rep(8'd3), rep(8'd3));

    set_all(8'd201); do_frame("clamp0", 1'b0); check_bus("clamp0", rep(8'd201), rep(8'd201));
    set_all(8'd200);
    do_frame("clamp1", 1'b0); check_bus("clamp1", rep(8'd200), rep(8'd201));
    do_frame("clamp2", 1'b0); check_bus("clamp2", rep(8'd200), rep(8'd201));
    do_frame("clamp3", 1'b0); check_bus("clamp3", rep(8'd200), rep(8'd200));

    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    for (int k = 0; k < 8; k++) begin
      sv[k] = 8'(20 * k + 1);
      exp_l[8*k +: 8] = 8'(20 * k + 1);
    end
    do_frame("pack", 1'b0); check_bus("pack", exp_l, exp_l);

    set_all(8'd100); do_frame("overrun", 1'b1);
    exp_l = {8'd136, 8'd119, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100};
    exp_p = {8'd141, 8'd121, 8'd101, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100};
    check_bus("overrun", exp_l, exp_p);

    set_all(8'd99);
    @(negedge clk); valid = 1'b1; clear = 1'b1;
    @(negedge clk); valid = 1'b0; clear = 1'b0;
    check_bus("clrvalid", 64'd0, 64'd0);
    chk("clrvalid_busy", 64'(busy), 64'd0);
    chk("clrvalid_drop", 64'(drop), 64'd0);
    expect_quiet("clrvalid");

    set_all(8'd200); do_frame("pre_rst", 1'b0); check_bus("pre_rst", rep(8'd200), rep(8'd200));
    set_all(8'd10);
    @(negedge clk); valid = 1'b1;
    @(negedge clk); valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_bus("midrst", 64'd0, 64'd0);
    chk("midrst_busy",      64'(busy),      64'd0);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_drop",      64'(drop),      64'd0);
    rst = 1'b0;
    expect_quiet("midrst");
    set_all(8'd50); do_frame("post_rst", 1'b0); check_bus("post_rst", rep(8'd50), rep(8'd50));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
